// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: ring-buffered framer emitting overlapping FRAME_LEN-sample frames every HOP samples.
// Build option AUDIO_FRAME_PREEMPH_EN enables 31/32 pre-emphasis on the write path.
module audio_frame_buffer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned HOP       = 128,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              frame_drop,
    output logic              overrun
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned IDX_W = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, pend_addr, pend_addr_nxt, trig_addr;
    logic [IDX_W-1:0]  smp_cnt, beat, beat_nxt;
    logic              primed, pending, pending_nxt;
    logic              trig, hs, end_frame, take, drop, rd_en;
    logic              out_valid_nxt, out_first_nxt, out_last_nxt;

`ifdef AUDIO_FRAME_PREEMPH_EN
    localparam int unsigned EXT_W = DATA_W + 2;
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;

    logic [DATA_W-1:0]       x_prev;
    logic signed [EXT_W-1:0] x_ext, xp_ext, y_ext;

    assign x_ext  = {{2{in_sample[DATA_W-1]}}, in_sample};
    assign xp_ext = {{2{x_prev[DATA_W-1]}}, x_prev};
    assign y_ext  = x_ext - xp_ext + (xp_ext >>> 5);

    // Saturate the widened difference back to the sample width
    always_comb begin
        wr_data = y_ext[DATA_W-1:0];
        if (y_ext > SAT_HI) begin
            wr_data = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (y_ext < SAT_LO) begin
            wr_data = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev <= '0;
        end else if (in_valid) begin
            x_prev <= in_sample;
        end
    end
`else
    assign wr_data = in_sample;
`endif

    // First trigger after FRAME_LEN samples, then one every HOP samples
    assign trig      = in_valid && (smp_cnt == (primed ? IDX_W'(HOP - 1) : IDX_W'(FRAME_LEN - 1)));
    assign trig_addr = wr_ptr + ADDR_W'(1) - ADDR_W'(FRAME_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            smp_cnt <= '0;
            primed  <= 1'b0;
        end else if (in_valid) begin
            wr_ptr  <= wr_ptr + ADDR_W'(1);
            smp_cnt <= trig ? '0 : smp_cnt + IDX_W'(1);
            primed  <= primed | trig;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // RAM read register doubles as the output data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (rd_en) begin
            out_data <= mem[rd_ptr];
        end
    end

    assign hs        = out_valid && out_ready;
    assign end_frame = (state == S_STREAM) && hs && out_last;
    assign take      = ((state == S_IDLE) && pending) || (end_frame && (pending || trig));
    assign drop      = trig && pending && !take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pending) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_STREAM;
            S_STREAM: if (end_frame) state_nxt = (pending || trig) ? S_LOAD : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (drop) begin
            state_nxt = S_LOAD;
        end
    end

    always_comb begin
        pending_nxt   = pending;
        pend_addr_nxt = pend_addr;
        rd_ptr_nxt    = rd_ptr;
        beat_nxt      = beat;
        rd_en         = 1'b0;
        out_valid_nxt = out_valid;
        out_first_nxt = out_first;
        out_last_nxt  = out_last;
        if (take) begin
            pending_nxt   = 1'b0;
            rd_ptr_nxt    = pending ? pend_addr : trig_addr;
            out_valid_nxt = 1'b0;
            out_first_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            if (pending && trig) begin
                pending_nxt   = 1'b1;
                pend_addr_nxt = trig_addr;
            end
        end else if (drop) begin
            // Abort the current frame and jump straight to the newest one
            pending_nxt   = 1'b0;
            rd_ptr_nxt    = trig_addr;
            out_valid_nxt = 1'b0;
            out_first_nxt = 1'b0;
            out_last_nxt  = 1'b0;
        end else begin
            if (trig) begin
                pending_nxt   = 1'b1;
                pend_addr_nxt = trig_addr;
            end
            if (state == S_LOAD) begin
                rd_en         = 1'b1;
                rd_ptr_nxt    = rd_ptr + ADDR_W'(1);
                beat_nxt      = '0;
                out_valid_nxt = 1'b1;
                out_first_nxt = 1'b1;
                out_last_nxt  = 1'b0;
            end else if ((state == S_STREAM) && hs) begin
                if (out_last) begin
                    out_valid_nxt = 1'b0;
                    out_first_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                end else begin
                    rd_en         = 1'b1;
                    rd_ptr_nxt    = rd_ptr + ADDR_W'(1);
                    beat_nxt      = beat + IDX_W'(1);
                    out_first_nxt = 1'b0;
                    out_last_nxt  = (beat == IDX_W'(FRAME_LEN - 2));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            pend_addr  <= '0;
            rd_ptr     <= '0;
            beat       <= '0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_drop <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            pending    <= pending_nxt;
            pend_addr  <= pend_addr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            beat       <= beat_nxt;
            out_valid  <= out_valid_nxt;
            out_first  <= out_first_nxt;
            out_last   <= out_last_nxt;
            frame_drop <= drop;
            overrun    <= overrun | drop;
        end
    end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Scoreboard bench for audio_frame_buffer: sample-history reference model feeds an expected-beat queue.
module tb_audio_frame_buffer;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 256;
    localparam int HOP       = 128;
    localparam int ADDR_W    = 9;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_sample;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;
    logic              frame_drop;
    logic              overrun;

    audio_frame_buffer #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .HOP      (HOP),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sample (in_sample),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .frame_drop(frame_drop),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass = 0;
    beat_t exp_q[$];
    int    hist[$];
    int    discard = 0;
    int    beats_seen = 0;
    int    drop_seen = 0;
    int    valid_cycles = 0;
    int    cyc = 0;
    int    first_cyc = 0;
    bit    gap_check = 1'b0;
    bit    done = 1'b0;

    function automatic void check(string name, int act, int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endfunction

`ifdef AUDIO_FRAME_PREEMPH_EN
    int xp = 0;
    function automatic int pre_emph(int x, int p);
        int y;
        y = x - p + (p >>> 5);
        if (y > (1 << (DATA_W - 1)) - 1) y = (1 << (DATA_W - 1)) - 1;
        if (y < -(1 << (DATA_W - 1)))    y = -(1 << (DATA_W - 1));
        return y;
    endfunction
`endif

    // Reference model: keep every stored sample; a trigger emits the last FRAME_LEN of them
    function automatic void model_write(input logic [DATA_W-1:0] v);
        int    s;
        int    n;
        beat_t b;
`ifdef AUDIO_FRAME_PREEMPH_EN
        s  = pre_emph(int'($signed(v)), xp);
        xp = int'($signed(v));
`else
        s = int'(v);
`endif
        hist.push_back(s);
        n = hist.size();
        if (n >= FRAME_LEN && (n - FRAME_LEN) % HOP == 0) begin
            if (discard > 0) begin
                discard--;
            end else begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    b.data  = DATA_W'(hist[n - FRAME_LEN + i]);
                    b.first = (i == 0);
                    b.last  = (i == FRAME_LEN - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endfunction

    function automatic void flush_model();
        exp_q.delete();
        hist.delete();
        discard   = 0;
        drop_seen = 0;
`ifdef AUDIO_FRAME_PREEMPH_EN
        xp = 0;
`endif
    endfunction

    task automatic send(input logic [DATA_W-1:0] v);
        in_sample = v;
        in_valid  = 1'b1;
        model_write(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(4);
    endtask

    // Monitor: pops expected beats on handshakes and checks stall stability
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_first = 1'b0;
    logic              prev_last = 1'b0;
    beat_t             e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid) valid_cycles++;
            if (frame_drop) drop_seen++;
            if (prev_stall && out_valid) begin
                check("stall_hold", int'({out_data, out_first, out_last}),
                      int'({prev_data, prev_first, prev_last}));
            end
            if (out_valid && out_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", int'(out_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", int'(out_data), int'(e.data));
                    check("beat_flags", int'({out_first, out_last}), int'({e.first, e.last}));
                end
                if (gap_check && out_first) first_cyc = cyc;
                if (gap_check && out_last) check("frame_gap", cyc - first_cyc, FRAME_LEN - 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_first = out_first;
            prev_last  = out_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #3;
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_first", int'(out_first), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_frame_drop", int'(frame_drop), 0);
        check("rst_overrun", int'(overrun), 0);
        apply_reset();

        // First frame: ramp 0..255, latency to first beat
        gap_check = 1'b1;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            send(DATA_W'(i));
            idle(3);
        end
        send(DATA_W'(FRAME_LEN - 1));
        @(negedge clk);
        check("lat_edge_t", int'(out_valid), 0);
        @(negedge clk);
        check("lat_edge_t1", int'(out_valid), 0);
        @(negedge clk);
        check("lat_edge_t2", int'(out_valid), 1);
        @(posedge clk);
        #1;
        drain(2000);

        // Second frame after one hop
        for (int i = FRAME_LEN; i < FRAME_LEN + HOP; i++) begin
            send(DATA_W'(i));
            idle(3);
        end
        drain(2000);
        check("t2_drop_count", drop_seen, 0);
        check("t2_overrun", int'(overrun), 0);

        // Random data with random back-pressure over four frames
        gap_check = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4 * HOP; i++) begin
                    send(DATA_W'($urandom));
                    idle($urandom_range(5, 9));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain(4000);
        check("t3_drop_count", drop_seen, 0);
        check("t3_overrun", int'(overrun), 0);

        // Overrun: sink stalled through two extra hops
        apply_reset();
        out_ready = 1'b0;
        discard   = 2;
        for (int i = 0; i < FRAME_LEN + 2 * HOP; i++) begin
            send(DATA_W'(i));
            idle(3);
        end
        idle(5);
        check("t4_drop_count", drop_seen, 1);
        check("t4_overrun_set", int'(overrun), 1);
        out_ready = 1'b1;
        drain(2000);
        check("t4_overrun_sticky", int'(overrun), 1);
        check("t4_drop_once", drop_seen, 1);

        // Reset in the middle of a streaming frame
        gap_check = 1'b1;
        base = beats_seen;
        for (int i = FRAME_LEN + 2 * HOP; i < FRAME_LEN + 3 * HOP; i++) begin
            send(DATA_W'(i));
            idle(3);
        end
        k = 0;
        while ((beats_seen - base) < 100 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_beat100", int'((beats_seen - base) >= 100), 1);
        #2;
        rst_n = 1'b0;
        flush_model();
        #1;
        check("t5_rst_out_valid", int'(out_valid), 0);
        check("t5_rst_overrun", int'(overrun), 0);
        check("t5_rst_out_last", int'(out_last), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            send(DATA_W'($urandom));
            idle(3);
        end
        idle(10);
        check("t5_no_early_frame", valid_cycles, 0);
        send(DATA_W'($urandom));
        drain(2000);
        check("t5_overrun_clear", int'(overrun), 0);

`ifdef AUDIO_FRAME_PREEMPH_EN
        // Pre-emphasis saturation corners
        apply_reset();
        send(DATA_W'(1000));
        idle(3);
        send(DATA_W'(1000));
        idle(3);
        send(DATA_W'(16'h8000));
        idle(3);
        send(DATA_W'(16'h7FFF));
        idle(3);
        for (int i = 4; i < FRAME_LEN; i++) begin
            send('0);
            idle(3);
        end
        drain(2000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_frame_buffer.md
Name: audio_frame_buffer

Overview:
- Sits directly downstream of the I2S mic receiver and consumes its 16-bit left-channel sample and its one-cycle sample_valid strobe.
- Stores samples in a circular on-chip RAM and cuts them into overlapping analysis frames (FRAME_LEN samples, advancing HOP samples per frame).
- Streams each frame out over a valid/ready interface to the feature-extraction stage (window/FFT).

Parameters:
- DATA_W, 16, sample width in bits.
- FRAME_LEN, 256, samples per frame; power of 2.
- HOP, 128, new samples between frame starts; must satisfy 1 ≤ HOP ≤ FRAME_LEN/2.
- ADDR_W, 9, ring address width; ring depth = 2^ADDR_W = 2*FRAME_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous assert, active-low; clock clk.
- in_sample  in  DATA_W  signed PCM sample from the I2S receiver.
- in_valid  in  1  one-cycle strobe; in_sample is valid in that cycle.
- out_data  out  DATA_W  frame sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the beat when out_valid && out_ready.
- out_first  out  1  high on the first beat of a frame.
- out_last  out  1  high on beat FRAME_LEN-1 of a frame.
- frame_drop  out  1  one-cycle pulse when a frame is aborted or discarded.
- overrun  out  1  sticky; set on any drop and cleared only by reset.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_first=0, out_last=0, frame_drop=0, overrun=0. Internal: wr_ptr=0, sample count=0, pending=0, FSM=IDLE. RAM contents are don't-care.
- Write path:
  - Each in_valid writes the sample at wr_ptr, then wr_ptr increments, wrapping mod 2^ADDR_W.
  - in_valid is never back-pressured; writes occur regardless of output state.
- Frame trigger:
  - The in_valid that writes the FRAME_LEN-th sample since reset is a trigger; after that, every HOP-th subsequent in_valid is a trigger.
  - On a trigger, the frame start address (wr_ptr + 1 - FRAME_LEN, mod depth, i.e. the address of this frame's first sample) is latched and pending is set.
- FSM states:
  - IDLE: when pending=1, clear pending, load the read pointer and go to LOAD.
  - LOAD: issue the synchronous RAM read; go to STREAM.
  - STREAM: present beats. On each handshake, advance the read pointer. The handshake on out_last returns the FSM to IDLE, or to LOAD directly if pending=1.
- Latency: a trigger in_valid sampled at edge T with the FSM idle gives out_valid=1 after edge T+2.
- Throughput: with out_ready held high, one beat per clock with no bubbles inside a frame (prefetch/skid as needed).
- Stall rule: while out_valid=1 && out_ready=0, out_data, out_first and out_last hold stable.
- Only one frame may be pending. A trigger while pending=1 is an overrun:
  - The current STREAM frame aborts immediately: out_valid drops next cycle and no out_last is issued.
  - frame_drop pulses and overrun sets.
  - The old pending frame is discarded; pending now holds the newest start address.
  - The FSM goes to LOAD.
  - This guarantees the ring never overwrites unread data of the frame being streamed.
- Simultaneous events:
  - A trigger in the same cycle as the out_last handshake is not an overrun; the FSM goes to LOAD for that frame.
  - A trigger in the same cycle the FSM clears pending (IDLE→LOAD) re-sets pending; it is not an overrun.
- Reset mid-frame: all outputs go to reset values immediately (async). The first frame after release needs FRAME_LEN fresh samples.

Optional Feature:
- Macro: AUDIO_FRAME_PREEMPH_EN.
- Defined: pre-emphasis is applied on the write path before storage: y[n] = x[n] - x[n-1] + (x[n-1] >>> 5), i.e. coefficient 31/32.
  - Computed in DATA_W+2 signed bits and saturated to DATA_W.
  - x[-1]=0 after reset.
  - Adds no write latency; the stored value is y[n] in the same cycle.
- Undefined: raw samples are stored unchanged.

Test Plan:
- Reset, then 256 in_valid with in_sample = 0..255 (stride ≥4 clk), out_ready=1 → one frame, out_data 0..255 in order; out_first on 0, out_last on 255; out_valid high after edge T+2 of the 256th write.
- Continue with 128 more samples 256..383 → second frame 128..383, no drop, overrun=0.
- Random out_ready (50%) over 4 frames of a ramp input → every frame content exact, outputs held stable during stalls, no gaps other than those caused by out_ready=0.
- Hold out_ready=0 from the first frame through 256 extra samples → frame_drop pulses once, overrun=1 (sticky), then the newest frame (start 256) streams 256..511 when out_ready=1.
- Assert rst_n=0 mid-STREAM at beat 100 → out_valid=0 and overrun=0 immediately; after release, no frame until 256 new samples.
- With AUDIO_FRAME_PREEMPH_EN: inputs 1000, 1000, -32768, 32767 → stored 1000, 31, -32768 (saturated), 32767 (saturated).
